plic_claim_sequencer: RTL and testbench
=======================================

# plic_claim_sequencer

Hardware claim/complete sequencer for one PLIC target context. When the context's `eip` line is high, the block reads the claim/complete register over the PLIC register bus and hands the claimed source ID to a hardware consumer through a valid/ready port. It waits for the consumer's done pulse, then writes the same ID back to complete the interrupt. It sits between a `plic_top` instance (as a register-bus master) and an accelerator that services interrupts without CPU involvement.

## Interface
Parameters:
- `N_SOURCE`, 30, number of PLIC sources.
- `SRCW`, `$clog2(N_SOURCE+1)`, ID width.
- `CC_ADDR`, 32'h0020_0004, byte address of this context's claim/complete register.
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in WAIT_DONE; used only with the timeout macro; must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  allows new claims; does not abort a claim in flight.
- `eip_i`  in  1  PLIC target interrupt line for this context.
- `req_o`  out  `reg_intf::reg_intf_req_a32_d32`  register-bus request (addr, write, wdata, wstrb, valid).
- `resp_i`  in  `reg_intf::reg_intf_resp_d32`  register-bus response (rdata, error, ready).
- `id_valid_o`  out  1  claimed ID available.
- `id_o`  out  SRCW  claimed source ID.
- `id_ready_i`  in  1  consumer accepts ID.
- `done_i`  in  1  one-cycle pulse: consumer finished servicing.
- `busy_o`  out  1  FSM not in IDLE.
- `err_o`  out  1  one-cycle pulse on bus error response.
- `timeout_o`  out  1  one-cycle pulse on consumer timeout; constant 0 without the macro.

## Operation
- States: IDLE, CLAIM, DISPATCH, WAIT_DONE, COMPLETE.
- IDLE → CLAIM when `enable_i && eip_i`.
- CLAIM:
  - `valid=1`, `write=0`, `addr=CC_ADDR`, `wstrb=0`.
  - On `valid && ready`, capture `rdata[SRCW-1:0]` into `id_q`.
  - If `error`: pulse `err_o` and go to IDLE.
  - Else if the ID is 0 (spurious claim): go to IDLE; no complete is written.
  - Else go to DISPATCH.
- DISPATCH: `id_valid_o=1`, `id_o=id_q`. On `id_ready_i` → WAIT_DONE.
- WAIT_DONE: on `done_i` → COMPLETE. A `done_i` pulse in any other state is ignored.
- COMPLETE:
  - `valid=1`, `write=1`, `addr=CC_ADDR`, `wdata={'0,id_q}`, `wstrb=4'hF`.
  - On `valid && ready` → IDLE. If `error`, also pulse `err_o`; the transaction is not retried.
- Bus rule: once `valid` is asserted, `valid` and all request fields stay stable until the cycle with `ready=1`. The request is never withdrawn.
- `id_o` holds `id_q` in all states. It is only meaningful while `id_valid_o` is high.
- Dropping `enable_i` mid-sequence has no effect; the sequence runs to IDLE.
- Back-to-back interrupts: IDLE re-samples `eip_i`. A stale `eip_i` yields a zero claim, which is handled as spurious.

## Timing
- Reset values: `req_o` all fields 0, `id_valid_o=0`, `id_o=0`, `busy_o=0`, `err_o=0`, `timeout_o=0`, state IDLE, `id_q=0`.
- All outputs come from registered state. `req_o` and `id_valid_o` are decoded from the state register; there is no combinational path from `resp_i` or `id_ready_i` to any output.
- Minimum latency with zero-wait bus, immediate `id_ready_i` and immediate `done_i`:
  - `eip_i` sampled high at edge 0 → claim `valid` visible after edge 0.
  - `id_valid_o` high after edge 1.
  - Complete `valid` high after edge 3.
  - IDLE after edge 4.
- `err_o` and `timeout_o` are high for exactly the cycle after the triggering edge.

## Configuration
- `PLIC_CLAIM_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle in it.
  - When it reaches `TIMEOUT_CYCLES` without `done_i`, pulse `timeout_o` and go to COMPLETE, which releases the gateway.
  - If `done_i` arrives in the same cycle as the limit, `done_i` wins and there is no pulse.
  - Counter width: `$clog2(TIMEOUT_CYCLES+1)`; saturating; no wrap.
- `PLIC_CLAIM_TIMEOUT_EN` undefined: no counter exists, WAIT_DONE waits indefinitely, and `timeout_o` is tied to 0.

## Structure
- Package `plic_seq_pkg` contains:
  - the state enum `plic_seq_state_e`;
  - the constant `PLIC_CC_BASE = 32'h0020_0004`;
  - the constant `PLIC_CC_STRIDE = 32'h1000`;
  - the function `cc_addr(target)` that computes `CC_ADDR`.
- One sub-module, `plic_seq_timeout`, holds the WAIT_DONE counter (ports: clear, count, expired). It is instantiated only under the macro.

## Test plan
- `eip_i=1`, bus returns `rdata=5` with zero wait, `id_ready_i=1`, `done_i` pulses 3 cycles later → `id_o=5` presented; then a write of `wdata=5` to `CC_ADDR`; then IDLE with `busy_o=0`.
- Claim returns `rdata=0` → no `id_valid_o`, no write transaction, back in IDLE.
- Bus `ready` held low for 4 cycles during CLAIM and during COMPLETE → request fields are bit-stable for all held cycles; exactly one read and one write occur.
- Claim response has `error=1` → `err_o` pulses once, FSM returns to IDLE, `id_valid_o` never asserts.
- With `PLIC_CLAIM_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, `done_i` is never sent → `timeout_o` pulses 8 cycles after entering WAIT_DONE, then the complete write occurs. Separately, `done_i` sent on cycle 8 → no `timeout_o` pulse.
- Assert `rst_ni` low during WAIT_DONE with `id_q=7` → all outputs return to reset values asynchronously. After release, no complete is written until a new claim occurs.

Source files
------------

// File: rtl/plic_seq_pkg.sv
// Shared types and address helpers for the PLIC claim/complete sequencer.
package plic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLAIM     = 3'd1,
    DISPATCH  = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } plic_seq_state_e;

  localparam logic [31:0] PLIC_CC_BASE   = 32'h0020_0004;
  localparam logic [31:0] PLIC_CC_STRIDE = 32'h1000;
  localparam logic [3:0]  WSTRB_ALL      = 4'hF;

  // Byte address of the claim/complete register of a given target context.
  function automatic logic [31:0] cc_addr(input int unsigned target);
    return PLIC_CC_BASE + 32'(target) * PLIC_CC_STRIDE;
  endfunction

endpackage

// File: rtl/reg_intf_pkg.sv
// Register-bus payload types shared by the PLIC register masters and slaves.
package reg_intf;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Request from a register-bus master.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              valid;
  } reg_intf_req_a32_d32;

  // Response from a register-bus slave.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_sequencer_timeout.sv
// WAIT_DONE watchdog counter; instantiated only when PLIC_CLAIM_TIMEOUT_EN is defined.
module plic_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0] SAT   = CNTW'(TIMEOUT_CYCLES);

  logic [CNTW-1:0] cnt_q;

  // Count edges spent waiting; holds at the limit instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES is the expiry edge.
  assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/plic_claim_sequencer.sv
// Claim/complete sequencer for one PLIC target context: claims on eip, hands the
// ID to a hardware consumer, then writes it back to complete the interrupt.
// Optional consumer watchdog: define PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_sequencer
  import plic_seq_pkg::*;
#(
  parameter int unsigned N_SOURCE       = 30,
  parameter int unsigned SRCW           = $clog2(N_SOURCE + 1),
  parameter logic [31:0] CC_ADDR        = cc_addr(0),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         eip_i,
  output reg_intf::reg_intf_req_a32_d32 req_o,
  input  reg_intf::reg_intf_resp_d32   resp_i,
  output logic                         id_valid_o,
  output logic [SRCW-1:0]              id_o,
  input  logic                         id_ready_i,
  input  logic                         done_i,
  output logic                         busy_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam reg_intf::reg_intf_req_a32_d32 CLAIM_REQ = '{
    addr:  CC_ADDR,
    write: 1'b0,
    wdata: 32'h0,
    wstrb: 4'h0,
    valid: 1'b1
  };

  plic_seq_state_e               state_q;
  logic [SRCW-1:0]               id_q;
  logic [SRCW-1:0]               rdata_id;
  reg_intf::reg_intf_req_a32_d32 complete_req;
  logic                          unused_rdata;

  assign rdata_id     = resp_i.rdata[SRCW-1:0];
  assign unused_rdata = ^resp_i.rdata[31:SRCW];
  assign id_o         = id_q;

  // Completion write carries the claimed ID zero-extended to the bus width.
  assign complete_req = '{
    addr:  CC_ADDR,
    write: 1'b1,
    wdata: 32'(id_q),
    wstrb: WSTRB_ALL,
    valid: 1'b1
  };

`ifdef PLIC_CLAIM_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_count;
  logic tmo_expired;
  logic timeout_q;

  assign tmo_clear = (state_q != WAIT_DONE);
  assign tmo_count = (state_q == WAIT_DONE);
  assign timeout_o = timeout_q;

  plic_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (tmo_clear),
    .count  (tmo_count),
    .expired(tmo_expired)
  );
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_o  = 1'b0;
`endif

  // Sequencer FSM; bus request and handshake outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      req_o      <= '0;
      id_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef PLIC_CLAIM_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      err_o <= 1'b0;
`ifdef PLIC_CLAIM_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (enable_i && eip_i) begin
            state_q <= CLAIM;
            req_o   <= CLAIM_REQ;
            busy_o  <= 1'b1;
          end
        end

        CLAIM: begin
          // Request stays up unchanged until the slave is ready.
          if (resp_i.ready) begin
            id_q  <= rdata_id;
            req_o <= '0;
            if (resp_i.error) begin
              err_o   <= 1'b1;
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else if (rdata_id == '0) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              id_valid_o <= 1'b1;
              state_q    <= DISPATCH;
            end
          end
        end

        DISPATCH: begin
          if (id_ready_i) begin
            id_valid_o <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (done_i) begin
            req_o   <= complete_req;
            state_q <= COMPLETE;
          end
`ifdef PLIC_CLAIM_TIMEOUT_EN
          else if (tmo_expired) begin
            timeout_q <= 1'b1;
            req_o     <= complete_req;
            state_q   <= COMPLETE;
          end
`endif
        end

        COMPLETE: begin
          // A failed completion is reported but never retried.
          if (resp_i.ready) begin
            req_o   <= '0;
            err_o   <= resp_i.error;
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          state_q    <= IDLE;
          req_o      <= '0;
          id_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Scoreboard bench for plic_claim_sequencer: stimulus queues expected bus
// transactions and dispatched IDs, a monitor pops and compares them.
module tb_plic_claim_sequencer;

  localparam logic [31:0] CC = 32'h0020_0004;

  logic clk;
  logic rst_n;
  logic enable;
  logic eip;
  logic id_ready;
  logic done;
  reg_intf::reg_intf_req_a32_d32 req;
  reg_intf::reg_intf_resp_d32    resp;
  logic       id_valid;
  logic [4:0] id;
  logic       busy;
  logic       err;
  logic       tmo;

  int n_checks    = 0;
  int n_errors    = 0;
  int bus_hs_cnt  = 0;
  int id_hs_cnt   = 0;
  int err_pulses  = 0;
  int tmo_pulses  = 0;
  int stab_checks = 0;
  int hold        = 0;

  int          bus_wait;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_err;

  reg_intf::reg_intf_req_a32_d32 exp_bus[$];
  logic [4:0]                    exp_id[$];
  reg_intf::reg_intf_req_a32_d32 prev_req;
  logic                          prev_pending = 1'b0;

  plic_claim_sequencer #(
    .N_SOURCE      (30),
    .CC_ADDR       (CC),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .enable_i  (enable),
    .eip_i     (eip),
    .req_o     (req),
    .resp_i    (resp),
    .id_valid_o(id_valid),
    .id_o      (id),
    .id_ready_i(id_ready),
    .done_i    (done),
    .busy_o    (busy),
    .err_o     (err),
    .timeout_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic reg_intf::reg_intf_req_a32_d32 mk_req(input logic wr, input logic [31:0] wd);
    reg_intf::reg_intf_req_a32_d32 r;
    r.addr  = CC;
    r.write = wr;
    r.wdata = wd;
    r.wstrb = wr ? 4'hF : 4'h0;
    r.valid = 1'b1;
    return r;
  endfunction

  // Bus slave model: holds ready low for bus_wait cycles per request.
  always @(negedge clk) begin
    if (req.valid) begin
      if (hold < bus_wait) begin
        resp = '0;
        hold++;
      end else begin
        resp.ready = 1'b1;
        resp.rdata = req.write ? 32'h0 : rd_data;
        resp.error = req.write ? wr_err : rd_err;
        hold = 0;
      end
    end else begin
      resp = '0;
      hold = 0;
    end
  end

  // Monitor: request stability, bus and ID handshakes against the scoreboard, pulse counts.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        stab_checks++;
        chk("req_stable", 128'(req), 128'(prev_req));
      end
      if (req.valid && resp.ready) begin
        bus_hs_cnt++;
        if (exp_bus.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL bus_unexpected: got request 0x%0h expected none", req);
        end else begin
          chk("bus_txn", 128'(req), 128'(exp_bus.pop_front()));
        end
      end
      prev_pending = req.valid && !resp.ready;
      prev_req     = req;
      if (id_valid && id_ready) begin
        id_hs_cnt++;
        if (exp_id.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL id_unexpected: got id %0d expected none", id);
        end else begin
          chk("id_dispatch", 128'(id), 128'(exp_id.pop_front()));
        end
      end
      if (err) err_pulses++;
      if (tmo) tmo_pulses++;
    end
  end

  task automatic wait_id(input string nm, input int id0, output logic ok);
    int i;
    i = 0;
    while ((id_hs_cnt == id0) && (i < 100)) begin
      @(posedge clk); #1;
      i++;
    end
    ok = (id_hs_cnt != id0);
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_id_wait: got no dispatch expected one", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (busy && (i < 200)) begin
      @(posedge clk); #1;
      i++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_idle_wait: got busy=1 expected 0", nm);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One full claim sequence; done_dly is the edge count after dispatch at which done is sampled.
  task automatic run_seq(input string nm, input logic [31:0] rdata, input logic rerr,
                         input logic werr, input int wt, input int done_dly, input logic drop_en);
    logic [4:0] cid;
    logic       live;
    logic       ok;
    int         e0;
    int         bh0;
    int         id0;
    cid  = rdata[4:0];
    live = !rerr && (cid != 5'd0);
    rd_data = rdata; rd_err = rerr; wr_err = werr; bus_wait = wt;
    exp_bus.push_back(mk_req(1'b0, 32'h0));
    if (live) begin
      exp_id.push_back(cid);
      exp_bus.push_back(mk_req(1'b1, 32'(cid)));
    end
    e0 = err_pulses; bh0 = bus_hs_cnt; id0 = id_hs_cnt;
    eip = 1'b1;
    @(posedge clk); #1;
    eip = 1'b0;
    if (drop_en) enable = 1'b0;
    if (live) begin
      wait_id(nm, id0, ok);
      if (ok) begin
        repeat (done_dly - 1) @(posedge clk);
        #1;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
      end
    end
    wait_idle(nm);
    enable = 1'b1;
    chk({nm, "_busy"}, 128'(busy), 128'(0));
    chk({nm, "_err_pulses"}, 128'(err_pulses - e0), 128'(rerr || (live && werr)));
    chk({nm, "_bus_txns"}, 128'(bus_hs_cnt - bh0), live ? 128'(2) : 128'(1));
    chk({nm, "_id_txns"}, 128'(id_hs_cnt - id0), live ? 128'(1) : 128'(0));
    chk({nm, "_queues_empty"}, 128'(exp_bus.size() + exp_id.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    int   s0;
    int   bh0;
    int   id0;
    int   t0;
    logic ok;
    rst_n = 1'b0; enable = 1'b0; eip = 1'b0; id_ready = 1'b1; done = 1'b0;
    bus_wait = 0; rd_data = 32'h0; rd_err = 1'b0; wr_err = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 128'(req), 128'(0));
    chk("rst_id_valid", 128'(id_valid), 128'(0));
    chk("rst_id", 128'(id), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_timeout", 128'(tmo), 128'(0));
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;

    // Basic sequence: ID 5, done three cycles after dispatch.
    run_seq("basic", 32'd5, 1'b0, 1'b0, 0, 3, 1'b0);

    // Minimum latency with ID 30, immediate done.
    rd_data = 32'd30; bus_wait = 0;
    exp_bus.push_back(mk_req(1'b0, 32'h0));
    exp_id.push_back(5'd30);
    exp_bus.push_back(mk_req(1'b1, 32'd30));
    eip = 1'b1;
    @(posedge clk); #1;
    eip = 1'b0;
    chk("lat_claim_valid", 128'(req.valid), 128'(1));
    chk("lat_claim_write", 128'(req.write), 128'(0));
    chk("lat_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    chk("lat_id_valid", 128'(id_valid), 128'(1));
    chk("lat_id_value", 128'(id), 128'(30));
    @(posedge clk); #1;
    chk("lat_id_dropped", 128'(id_valid), 128'(0));
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("lat_cmpl_valid", 128'(req.valid), 128'(1));
    chk("lat_cmpl_write", 128'(req.write), 128'(1));
    @(posedge clk); #1;
    chk("lat_idle", 128'(busy), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("lat_queues_empty", 128'(exp_bus.size() + exp_id.size()), 128'(0));

    // Spurious claim and upper rdata bits ignored.
    run_seq("spurious", 32'd0, 1'b0, 1'b0, 0, 1, 1'b0);
    run_seq("upper_bits", 32'hFFFF_FFE3, 1'b0, 1'b0, 0, 2, 1'b0);

    // Four-cycle bus stalls on both transactions, enable dropped mid-sequence.
    s0 = stab_checks;
    run_seq("stall", 32'd9, 1'b0, 1'b0, 4, 2, 1'b1);
    chk("stall_held_cycles", 128'(stab_checks - s0), 128'(8));

    // Bus errors on the claim read and on the completion write.
    run_seq("read_err", 32'd12, 1'b1, 1'b0, 0, 1, 1'b0);
    run_seq("write_err", 32'd17, 1'b0, 1'b1, 0, 1, 1'b0);
    wr_err = 1'b0;

    // Disabled: eip and a stray done do nothing.
    bh0 = bus_hs_cnt;
    enable = 1'b0; eip = 1'b1; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("disabled_busy", 128'(busy), 128'(0));
    chk("disabled_bus_txns", 128'(bus_hs_cnt - bh0), 128'(0));
    eip = 1'b0; enable = 1'b1;
    @(posedge clk); #1;

`ifdef PLIC_CLAIM_TIMEOUT_EN
    // Consumer never finishes: timeout after eight WAIT_DONE edges, then the write.
    rd_data = 32'd11; bus_wait = 0;
    exp_bus.push_back(mk_req(1'b0, 32'h0));
    exp_id.push_back(5'd11);
    exp_bus.push_back(mk_req(1'b1, 32'd11));
    t0 = tmo_pulses; id0 = id_hs_cnt;
    eip = 1'b1;
    @(posedge clk); #1;
    eip = 1'b0;
    wait_id("tmo", id0, ok);
    repeat (7) @(posedge clk);
    #1;
    chk("tmo_early", 128'(tmo), 128'(0));
    @(posedge clk); #1;
    chk("tmo_pulse", 128'(tmo), 128'(1));
    chk("tmo_cmpl_valid", 128'(req.valid), 128'(1));
    wait_idle("tmo");
    chk("tmo_pulse_count", 128'(tmo_pulses - t0), 128'(1));
    chk("tmo_queues_empty", 128'(exp_bus.size() + exp_id.size()), 128'(0));

    // done on the limit edge wins over the timeout.
    t0 = tmo_pulses;
    run_seq("done_at_limit", 32'd13, 1'b0, 1'b0, 0, 8, 1'b0);
    chk("done_at_limit_no_tmo", 128'(tmo_pulses - t0), 128'(0));
`else
    t0 = tmo_pulses;
    run_seq("long_wait", 32'd13, 1'b0, 1'b0, 0, 20, 1'b0);
    chk("no_timeout_pulses", 128'(tmo_pulses - t0), 128'(0));
`endif

    // Asynchronous reset while waiting on the consumer with ID 7.
    rd_data = 32'd7; bus_wait = 0;
    exp_bus.push_back(mk_req(1'b0, 32'h0));
    exp_id.push_back(5'd7);
    id0 = id_hs_cnt;
    eip = 1'b1;
    @(posedge clk); #1;
    eip = 1'b0;
    wait_id("areset", id0, ok);
    @(posedge clk); #1;
    chk("areset_pre_id", 128'(id), 128'(7));
    chk("areset_pre_busy", 128'(busy), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_req", 128'(req), 128'(0));
    chk("areset_id_valid", 128'(id_valid), 128'(0));
    chk("areset_id", 128'(id), 128'(0));
    chk("areset_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bh0 = bus_hs_cnt;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("areset_no_write", 128'(bus_hs_cnt - bh0), 128'(0));
    chk("areset_idle", 128'(busy), 128'(0));
    chk("areset_queues_empty", 128'(exp_bus.size() + exp_id.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
